// File: rtl/spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// spike_rate_encoder
//
// Transmit side of the single-bit spike interface. One unsigned intensity
// sample is taken through a valid/ready handshake and turned into a
// deterministic rate-coded spike train lasting WINDOW network timesteps.
// A phase accumulator adds the sample on every timestep. Its carry-out is
// the spike, so the number of spikes in a window is proportional to the
// sample.
//
// Ports
//   clk          in   single clock, rising-edge
//   rst          in   synchronous, active-high reset
//   in_valid     in   sample available
//   in_data      in   [DATA_WIDTH-1:0] unsigned intensity
//   in_ready     out  block can accept a sample (idle)
//   step_en      in   timestep strobe, one network timestep per high cycle
//   spike_out    out  registered one-cycle spike pulse
//   busy         out  window in progress
//   window_done  out  one-cycle pulse after the final timestep of a window
//   spike_count  out  [CNT_WIDTH-1:0] spikes emitted in the current/last window
// ---------------------------------------------------------------------------
module spike_rate_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  step_en,
  output logic                  spike_out,
  output logic                  busy,
  output logic                  window_done,
  output logic [CNT_WIDTH-1:0]  spike_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WINDOW - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [CNT_WIDTH-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_WIDTH-1:0]  spike_count_q, spike_count_d;
  logic                  spike_q, spike_d;
  logic                  done_q, done_d;

  // One bit wider than the accumulator: the top bit is the carry that
  // becomes the spike, the low bits are the wrapped phase.
  logic [DATA_WIDTH:0]   sum;

  // Next-state logic. Spike and done pulses default to 0 so they are only
  // ever high for the single cycle after a qualifying timestep.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    value_d       = value_q;
    step_cnt_d    = step_cnt_q;
    spike_count_d = spike_count_q;
    spike_d       = 1'b0;
    done_d        = 1'b0;
    sum           = {1'b0, acc_q} + {1'b0, value_q};

    unique case (state_q)
      IDLE: begin
        // Any step_en in the accept cycle is ignored; step 0 is the first
        // strobe seen while in RUN.
        if (in_valid) begin
          value_d       = in_data;
          acc_d         = '0;
          step_cnt_d    = '0;
          spike_count_d = '0;
          state_d       = RUN;
        end
      end

      RUN: begin
        if (step_en) begin
          acc_d         = sum[DATA_WIDTH-1:0];
          spike_d       = sum[DATA_WIDTH];
          spike_count_d = spike_count_q + {{(CNT_WIDTH-1){1'b0}}, sum[DATA_WIDTH]};
          step_cnt_d    = step_cnt_q + 1'b1;
          // Returning to IDLE on the final step makes in_ready rise in the
          // same cycle the last spike and window_done are visible.
          if (step_cnt_q == LAST_STEP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register. Reset aborts any train in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      value_q       <= '0;
      step_cnt_q    <= '0;
      spike_count_q <= '0;
      spike_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      step_cnt_q    <= step_cnt_d;
      spike_count_q <= spike_count_d;
      spike_q       <= spike_d;
      done_q        <= done_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign spike_out   = spike_q;
  assign window_done = done_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// Testbench for spike_rate_encoder.
// The main instance uses DATA_WIDTH=8, WINDOW=256. A second instance uses
// WINDOW=1 for the single-step window case.
// The reference model predicts each step's spike as
//   floor(v*(k+1)/256) - floor(v*k/256)
// which is the carry of a phase accumulator holding v*k mod 256.
// ---------------------------------------------------------------------------
module tb_spike_rate_encoder;

   localparam int DW  = 8;
   localparam int WIN = 256;
   localparam int CW  = 16;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          step_en;
   logic          spike_out;
   logic          busy;
   logic          window_done;
   logic [CW-1:0] spike_count;

   logic          w1Valid;
   logic [DW-1:0] w1Data;
   logic          w1Ready;
   logic          w1Step;
   logic          w1Spike;
   logic          w1Busy;
   logic          w1Done;
   logic [CW-1:0] w1Count;

   int numCompared;
   int numMismatched;

   // Expected outputs for the cycle following one driven clock edge.
   typedef struct {
      int spike;
      int done;
      int busy;
      int ready;
      int count;
   } exp_t;

   exp_t expQ[$];
   exp_t checkE;

   // Table of whole-window vectors: pattern 0 = step every cycle,
   // pattern 1 = step_en alternating 0,1,0,1 starting with 0.
   typedef struct {
      string name;
      int    data;
      int    pattern;
      int    expCount;
      int    expBusy;
   } vec_t;

   vec_t vecs[6];

   // Reference model state.
   bit mRun;
   int mStep;
   int mVal;
   int mCount;

   // DUT activity observed by the checker.
   int dutSpikes;
   int dutDones;
   int dutBusy;

   spike_rate_encoder #(.DATA_WIDTH(DW), .WINDOW(WIN), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .step_en     (step_en),
      .spike_out   (spike_out),
      .busy        (busy),
      .window_done (window_done),
      .spike_count (spike_count)
   );

   spike_rate_encoder #(.DATA_WIDTH(DW), .WINDOW(1), .CNT_WIDTH(CW)) dutW1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (w1Valid),
      .in_data     (w1Data),
      .in_ready    (w1Ready),
      .step_en     (w1Step),
      .spike_out   (w1Spike),
      .busy        (w1Busy),
      .window_done (w1Done),
      .spike_count (w1Count)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input int act, input int expv);
      numCompared++;
      if (act != expv) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Drives one cycle of inputs just after a rising edge, advances the model
   // and queues what the DUT must show after the next rising edge.
   task automatic applyStimulus(input logic r, input logic v, input int d, input logic s);
      exp_t e;
      int   carry;
      rst      = r;
      in_valid = v;
      in_data  = d[DW-1:0];
      step_en  = s;
      e.spike  = 0;
      e.done   = 0;
      if (r) begin
         mRun   = 1'b0;
         mStep  = 0;
         mVal   = 0;
         mCount = 0;
      end else if (!mRun) begin
         if (v) begin
            mRun   = 1'b1;
            mStep  = 0;
            mVal   = d;
            mCount = 0;
         end
      end else if (s) begin
         carry   = (mVal * (mStep + 1)) / (1 << DW) - (mVal * mStep) / (1 << DW);
         e.spike = carry;
         mCount += carry;
         if (mStep == WIN - 1) begin
            e.done = 1;
            mRun   = 1'b0;
         end
         mStep++;
      end
      e.busy  = mRun ? 1 : 0;
      e.ready = mRun ? 0 : 1;
      e.count = mCount;
      @(posedge clk);
      expQ.push_back(e);
      #1;
   endtask

   // Scoreboard consumer: compares every queued expectation on the falling
   // edge, away from the edge that updated the DUT.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkE = expQ.pop_front();
         checkOutput("spike_out",   int'(spike_out),   checkE.spike);
         checkOutput("window_done", int'(window_done), checkE.done);
         checkOutput("busy",        int'(busy),        checkE.busy);
         checkOutput("in_ready",    int'(in_ready),    checkE.ready);
         checkOutput("spike_count", int'(spike_count), checkE.count);
         if (spike_out)   dutSpikes++;
         if (window_done) dutDones++;
         if (busy)        dutBusy++;
      end
   end

   task automatic clearActivity();
      dutSpikes = 0;
      dutDones  = 0;
      dutBusy   = 0;
   endtask

   // Lets the checker consume the last queued expectation.
   task automatic drain();
      @(negedge clk);
      #1;
   endtask

   task automatic runVector(input vec_t tv);
      logic s;
      clearActivity();
      applyStimulus(1'b0, 1'b1, tv.data, 1'b1);
      for (int i = 0; i < tv.expBusy + 4; i++) begin
         s = (tv.pattern == 1) ? (i % 2 == 1) : 1'b1;
         applyStimulus(1'b0, 1'b0, tv.data, s);
      end
      drain();
      checkOutput({tv.name, " spikes"}, dutSpikes, tv.expCount);
      checkOutput({tv.name, " final_count"}, int'(spike_count), tv.expCount);
      checkOutput({tv.name, " done_pulses"}, dutDones, 1);
      checkOutput({tv.name, " busy_cycles"}, dutBusy, tv.expBusy);
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      mRun = 1'b0; mStep = 0; mVal = 0; mCount = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; step_en = 1'b0;
      w1Valid = 1'b0; w1Data = '0; w1Step = 1'b0;

      vecs[0] = '{"t2_d64",    64,  0, 64,  256};
      vecs[1] = '{"t3_d0",     0,   0, 0,   256};
      vecs[2] = '{"t3_d255",   255, 0, 255, 256};
      vecs[3] = '{"t4_d128",   128, 1, 128, 512};
      vecs[4] = '{"d1",        1,   0, 1,   256};
      vecs[5] = '{"d200",      200, 0, 200, 256};

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b1, 77, 1'b1);
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      drain();
      checkOutput("w1 in_ready after reset", int'(w1Ready), 1);

      foreach (vecs[i]) begin
         $display("[TB] window vector %s", vecs[i].name);
         runVector(vecs[i]);
      end

      $display("[TB] reset mid-window");
      clearActivity();
      applyStimulus(1'b0, 1'b1, 64, 1'b0);
      for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 64, 1'b1);
      applyStimulus(1'b1, 1'b1, 99, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 99, 1'b1);
      drain();
      checkOutput("reset_abort done_pulses", dutDones, 0);
      checkOutput("reset_abort spikes", dutSpikes, 25);

      $display("[TB] back-to-back with in_valid held");
      clearActivity();
      applyStimulus(1'b0, 1'b1, 64, 1'b1);
      for (int i = 0; i < 257; i++) applyStimulus(1'b0, 1'b1, 32, 1'b1);
      for (int i = 0; i < 259; i++) applyStimulus(1'b0, 1'b0, 32, 1'b1);
      drain();
      checkOutput("b2b done_pulses", dutDones, 2);
      checkOutput("b2b spikes", dutSpikes, 96);
      checkOutput("b2b final_count", int'(spike_count), 32);
      checkOutput("b2b busy_cycles", dutBusy, 512);

      $display("[TB] WINDOW=1 instance");
      w1Valid = 1'b1; w1Data = 8'd200; w1Step = 1'b1;
      @(posedge clk); #1;
      w1Valid = 1'b0;
      @(negedge clk);
      checkOutput("w1 busy after accept", int'(w1Busy), 1);
      checkOutput("w1 in_ready after accept", int'(w1Ready), 0);
      @(negedge clk);
      checkOutput("w1 spike_out", int'(w1Spike), 0);
      checkOutput("w1 window_done", int'(w1Done), 1);
      checkOutput("w1 in_ready at done", int'(w1Ready), 1);
      checkOutput("w1 busy at done", int'(w1Busy), 0);
      checkOutput("w1 spike_count", int'(w1Count), 0);
      @(negedge clk);
      checkOutput("w1 window_done pulse width", int'(w1Done), 0);
      checkOutput("w1 spike_out idle", int'(w1Spike), 0);
      w1Step = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
